// File: rtl/clk_div_bank.sv
// Bank of NUM_CH runtime-programmable clock dividers producing tick strobes and 50% squares.
// Optional debug override of every divisor is compiled in with CLK_DIV_BANK_DEBUG_EN.

module clk_div_lane #(
  parameter int unsigned CNT_W       = 24,
  parameter int unsigned DEFAULT_DIV = 13500000
) (
  input  logic             clk_27,
  input  logic             reset,
  input  logic             wr,
  input  logic [CNT_W-1:0] val,
  input  logic             sync,
  input  logic             force_en,
  input  logic [CNT_W-1:0] force_div,
  output logic             tick,
  output logic             sq
);
  localparam logic [CNT_W-1:0] DEF = CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0] pend, act, cnt;
  logic [CNT_W-1:0] pend_nxt, src;

  // A write landing on a reload edge is seen by that reload (write-through).
  assign pend_nxt = wr ? val : pend;
  assign src      = force_en ? force_div : pend_nxt;

  always_ff @(posedge clk_27 or posedge reset) begin
    if (reset) begin
      pend <= DEF;
      act  <= DEF;
      cnt  <= DEF;
      tick <= 1'b0;
      sq   <= 1'b0;
    end else begin
      pend <= pend_nxt;
      if (sync) begin
        act  <= src;
        cnt  <= src;
        sq   <= 1'b0;
        tick <= 1'b0;
      end else if (act != '0) begin
        if (cnt == CNT_W'(1)) begin
          tick <= 1'b1;
          sq   <= ~sq;
          act  <= src;
          cnt  <= src;
        end else begin
          tick <= 1'b0;
          cnt  <= cnt - CNT_W'(1);
        end
      end else begin
        // Disabled: hold sq, restart as soon as a non-zero divisor is available.
        tick <= 1'b0;
        if (src != '0) begin
          act <= src;
          cnt <= src;
        end
      end
    end
  end
endmodule

module clk_div_bank #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CNT_W       = 24,
  parameter int unsigned DEFAULT_DIV = 13500000
`ifdef CLK_DIV_BANK_DEBUG_EN
  , parameter int unsigned DEBUG_DIV = 1350000
`endif
) (
  input  logic                                    clk_27,
  input  logic                                    reset,
`ifdef CLK_DIV_BANK_DEBUG_EN
  input  logic                                    debug,
`endif
  input  logic                                    div_wr,
  input  logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0] div_sel,
  input  logic [CNT_W-1:0]                        div_val,
  input  logic                                    sync,
  output logic [NUM_CH-1:0]                       tick,
  output logic [NUM_CH-1:0]                       sq
);
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] wr_vec;
  logic              force_en;
  logic [CNT_W-1:0]  force_div;

`ifdef CLK_DIV_BANK_DEBUG_EN
  assign force_en  = debug;
  assign force_div = CNT_W'(DEBUG_DIV);
`else
  assign force_en  = 1'b0;
  assign force_div = '0;
`endif

  // Out-of-range selects match no lane and are dropped.
  always_comb begin
    wr_vec = '0;
    for (int i = 0; i < NUM_CH; i++)
      wr_vec[i] = div_wr && (div_sel == SEL_W'(i));
  end

  clk_div_lane #(
    .CNT_W      (CNT_W),
    .DEFAULT_DIV(DEFAULT_DIV)
  ) u_lane [NUM_CH-1:0] (
    .clk_27   (clk_27),
    .reset    (reset),
    .wr       (wr_vec),
    .val      (div_val),
    .sync     (sync),
    .force_en (force_en),
    .force_div(force_div),
    .tick     (tick),
    .sq       (sq)
  );
endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank: reset timing, D=1, period change, disable/restart, sync alignment.
module tb_clk_div_bank;
  logic        clk_27 = 1'b0;
  logic        reset;
  logic        div_wr;
  logic [1:0]  div_sel;
  logic [23:0] div_val;
  logic        sync;
  logic [3:0]  tick, sq;
`ifdef CLK_DIV_BANK_DEBUG_EN
  logic        debug;
`endif

  int nvec = 0;
  int nerr = 0;

  clk_div_bank #(
    .NUM_CH     (4),
    .CNT_W      (24),
    .DEFAULT_DIV(5)
`ifdef CLK_DIV_BANK_DEBUG_EN
    , .DEBUG_DIV(2)
`endif
  ) dut (
    .clk_27 (clk_27),
    .reset  (reset),
`ifdef CLK_DIV_BANK_DEBUG_EN
    .debug  (debug),
`endif
    .div_wr (div_wr),
    .div_sel(div_sel),
    .div_val(div_val),
    .sync   (sync),
    .tick   (tick),
    .sq     (sq)
  );

  always #5 clk_27 = ~clk_27;

  task automatic step();
    @(posedge clk_27);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    logic       et, es, et1, es1;
    reset = 1'b1; div_wr = 1'b0; div_sel = '0; div_val = '0; sync = 1'b0;
`ifdef CLK_DIV_BANK_DEBUG_EN
    debug = 1'b0;
`endif
    #2;
    chk("reset tick", 32'(tick), 32'h0);
    chk("reset sq",   32'(sq),   32'h0);
    step();
    reset = 1'b0;

    // Default divisor 5: all lanes tick at edges 5, 10, 15.
    es = 1'b0;
    for (int e = 1; e <= 15; e++) begin
      step();
      et = (e % 5 == 0);
      es ^= et;
      chk($sformatf("dflt tick e%0d", e), 32'(tick), et ? 32'hF : 32'h0);
      chk($sformatf("dflt sq0 e%0d", e),  32'(sq[0]), 32'(es));
    end

    // D=1 written together with sync: tick stuck high, sq toggles every cycle.
    div_wr = 1'b1; div_sel = 2'd0; div_val = 24'd1; sync = 1'b1;
    step();
    div_wr = 1'b0; sync = 1'b0;
    chk("d1 sync tick", 32'(tick), 32'h0);
    chk("d1 sync sq",   32'(sq),   32'h0);
    for (int e = 1; e <= 6; e++) begin
      step();
      chk($sformatf("d1 tick e%0d", e), 32'(tick[0]), 32'h1);
      chk($sformatf("d1 sq e%0d", e),   32'(sq[0]),   32'(e % 2));
    end

    // D=8, switch to 3 mid-period, then 0 (freeze), then 4 (restart).
    div_wr = 1'b1; div_val = 24'd8; sync = 1'b1;
    step();
    div_wr = 1'b0; sync = 1'b0;
    es = 1'b0;
    for (int e = 1; e <= 32; e++) begin
      div_wr  = (e == 3 || e == 12 || e == 23);
      div_val = (e == 3) ? 24'd3 : (e == 12) ? 24'd0 : 24'd4;
      step();
      div_wr = 1'b0;
      et = (e == 8 || e == 11 || e == 14 || e == 27 || e == 31);
      es ^= et;
      chk($sformatf("chg tick e%0d", e), 32'(tick[0]), 32'(et));
      chk($sformatf("chg sq e%0d", e),   32'(sq[0]),   32'(es));
    end

    // Lanes 0/1 at 3 and 6, aligned by sync.
    div_wr = 1'b1; div_sel = 2'd0; div_val = 24'd3;
    step();
    div_sel = 2'd1; div_val = 24'd6; sync = 1'b1;
    step();
    div_wr = 1'b0; sync = 1'b0;
    chk("align sq",   32'(sq[1:0]),   32'h0);
    chk("align tick", 32'(tick[1:0]), 32'h0);
    es = 1'b0; es1 = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      step();
      et  = (e % 3 == 0);
      et1 = (e % 6 == 0);
      es ^= et; es1 ^= et1;
      chk($sformatf("align tick e%0d", e), 32'(tick[1:0]), 32'({et1, et}));
      chk($sformatf("align sq e%0d", e),   32'(sq[1:0]),   32'({es1, es}));
    end

`ifdef CLK_DIV_BANK_DEBUG_EN
    // Debug forces D=2; after release the programmed 3/6 return at the next reload.
    debug = 1'b1; sync = 1'b1;
    step();
    sync = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      debug = (e < 5);
      step();
      if (e <= 4) begin
        et = (e % 2 == 0); et1 = et;
      end else begin
        et = (e % 3 == 0); et1 = (e % 6 == 0);
      end
      chk($sformatf("dbg tick e%0d", e), 32'(tick[1:0]), 32'({et1, et}));
    end
`endif

    // Async reset right after a tick edge clears outputs at once; restart from default.
    reset = 1'b1;
    #1;
    chk("midrst tick", 32'(tick), 32'h0);
    chk("midrst sq",   32'(sq),   32'h0);
    @(negedge clk_27);
    reset = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      step();
      chk($sformatf("rst tick e%0d", e), 32'(tick), (e % 5 == 0) ? 32'hF : 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
